// File: rtl/hazard_stall_unit.sv
// Stall/flush generator for the 5-stage pipeline: resolves the hazards forwarding
// cannot (load-use, branch operands in D, HI/LO vs. a multi-cycle mult/div) and redirects.
module hazard_stall_unit #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] rt_E,
  input  logic [4:0] writereg_E,
  input  logic       regwrite_E,
  input  logic       memtoreg_E,
  input  logic [4:0] writereg_M,
  input  logic       memtoreg_M,
  input  logic       branch_D,
  input  logic       branch_taken_D,
  input  logic       jump_D,
  input  logic       muldiv_D,
  input  logic       hilo_rd_D,
  input  logic       muldiv_start_E,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_D,
  output logic       flush_E,
  output logic       muldiv_busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MULDIV_LAT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lwstall, brstall, hlstall, stall;

  // A D-stage source that is still being produced upstream and cannot be bypassed
  // into the D-stage comparator: an ALU result in E or a load result in M.
  function automatic logic src_hazard(input logic [4:0] r,
                                      input logic       rw_e,
                                      input logic [4:0] wr_e,
                                      input logic       ld_m,
                                      input logic [4:0] wr_m);
    return (r != 5'd0) && ((rw_e && (wr_e == r)) || (ld_m && (wr_m == r)));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A start while busy restarts the full latency window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (muldiv_start_E) begin
          state_nxt = BUSY;
          cnt_nxt   = LAT;
        end
      end
      BUSY: begin
        if (muldiv_start_E) begin
          cnt_nxt = LAT;
        end else if (cnt == ONE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign muldiv_busy = (state == BUSY);

  assign lwstall = memtoreg_E && (rt_E != 5'd0) && ((rt_E == rs_D) || (rt_E == rt_D));

  // jr only reads rs, so rt is checked for conditional branches alone.
  assign brstall = ((branch_D || jump_D) &&
                    src_hazard(rs_D, regwrite_E, writereg_E, memtoreg_M, writereg_M)) ||
                   (branch_D &&
                    src_hazard(rt_D, regwrite_E, writereg_E, memtoreg_M, writereg_M));

  assign hlstall = (hilo_rd_D || muldiv_D) && (muldiv_busy || muldiv_start_E);

  assign stall = !reset && (lwstall || brstall || hlstall);

  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_E = stall;
  // Stall wins over redirect; the redirect fires once the stall drops.
  assign flush_D = !reset && !stall && ((branch_D && branch_taken_D) || jump_D);

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit: stimulus pushes expected outputs,
// a monitor pops and checks them on the falling edge of each cycle.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, rt_E, writereg_E, writereg_M;
  logic       regwrite_E, memtoreg_E, memtoreg_M;
  logic       branch_D, branch_taken_D, jump_D, muldiv_D, hilo_rd_D, muldiv_start_E;
  logic       stall_F, stall_D, flush_D, flush_E, muldiv_busy;

  typedef struct {
    string name;
    logic  stall;
    logic  flush_d;
    logic  busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULDIV_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .rt_E(rt_E),
    .writereg_E(writereg_E), .regwrite_E(regwrite_E), .memtoreg_E(memtoreg_E),
    .writereg_M(writereg_M), .memtoreg_M(memtoreg_M),
    .branch_D(branch_D), .branch_taken_D(branch_taken_D), .jump_D(jump_D),
    .muldiv_D(muldiv_D), .hilo_rd_D(hilo_rd_D), .muldiv_start_E(muldiv_start_E),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .muldiv_busy(muldiv_busy)
  );

  task automatic clear_inputs();
    reset = 1'b0; rs_D = '0; rt_D = '0; rt_E = '0; writereg_E = '0; writereg_M = '0;
    regwrite_E = 1'b0; memtoreg_E = 1'b0; memtoreg_M = 1'b0;
    branch_D = 1'b0; branch_taken_D = 1'b0; jump_D = 1'b0;
    muldiv_D = 1'b0; hilo_rd_D = 1'b0; muldiv_start_E = 1'b0;
  endtask

  // Inputs are already applied for this cycle; record what must be seen, then advance.
  task automatic issue(input string name, input logic s, input logic fd, input logic b);
    exp_t e;
    e.name = name; e.stall = s; e.flush_d = fd; e.busy = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (stall_F !== e.stall || stall_D !== e.stall || flush_E !== e.stall ||
            flush_D !== e.flush_d || muldiv_busy !== e.busy) begin
          n_fail++;
          $display("FAIL %s: got stall_F=%b stall_D=%b flush_E=%b flush_D=%b busy=%b, want stall=%b flush_E=%b flush_D=%b busy=%b",
                   e.name, stall_F, stall_D, flush_E, flush_D, muldiv_busy,
                   e.stall, e.stall, e.flush_d, e.busy);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Hazard conditions present during reset must be masked.
    memtoreg_E = 1'b1; rt_E = 5'd8; rs_D = 5'd8; hilo_rd_D = 1'b1; muldiv_start_E = 1'b1;
    jump_D = 1'b1;
    issue("reset_state", 1'b0, 1'b0, 1'b0);

    clear_inputs();
    memtoreg_E = 1'b1; rt_E = 5'd8; rs_D = 5'd8;
    issue("loaduse_rs", 1'b1, 1'b0, 1'b0);
    clear_inputs();
    memtoreg_E = 1'b1; rt_E = 5'd0; rs_D = 5'd0;
    issue("loaduse_r0", 1'b0, 1'b0, 1'b0);
    clear_inputs();
    memtoreg_E = 1'b1; rt_E = 5'd7; rt_D = 5'd7; rs_D = 5'd3;
    issue("loaduse_rt", 1'b1, 1'b0, 1'b0);

    clear_inputs();
    branch_D = 1'b1; branch_taken_D = 1'b1; rt_D = 5'd9; regwrite_E = 1'b1; writereg_E = 5'd9;
    issue("br_alu_E_stall", 1'b1, 1'b0, 1'b0);
    regwrite_E = 1'b0;
    issue("br_taken_redirect", 1'b0, 1'b1, 1'b0);

    clear_inputs();
    branch_D = 1'b1; rs_D = 5'd5; memtoreg_M = 1'b1; writereg_M = 5'd5;
    issue("br_load_M_stall", 1'b1, 1'b0, 1'b0);
    memtoreg_M = 1'b0;
    issue("br_alu_M_fwd", 1'b0, 1'b0, 1'b0);

    clear_inputs();
    jump_D = 1'b1; rs_D = 5'd31; regwrite_E = 1'b1; writereg_E = 5'd31;
    issue("jr_rs_stall", 1'b1, 1'b0, 1'b0);
    rs_D = 5'd0; rt_D = 5'd31;
    issue("jr_rt_ignored", 1'b0, 1'b1, 1'b0);

    clear_inputs();
    branch_D = 1'b1; rs_D = 5'd0; rt_D = 5'd0; regwrite_E = 1'b1; writereg_E = 5'd0;
    memtoreg_M = 1'b1; writereg_M = 5'd0;
    issue("br_r0_no_hazard", 1'b0, 1'b0, 1'b0);

    // mfhi held across a mult/div occupancy window.
    clear_inputs();
    hilo_rd_D = 1'b1; muldiv_start_E = 1'b1;
    issue("hilo_start", 1'b1, 1'b0, 1'b0);
    muldiv_start_E = 1'b0;
    for (int i = 1; i <= 4; i++) issue($sformatf("hilo_busy%0d", i), 1'b1, 1'b0, 1'b1);
    issue("hilo_free", 1'b0, 1'b0, 1'b0);

    clear_inputs();
    muldiv_D = 1'b1; muldiv_start_E = 1'b1;
    issue("md2_start", 1'b1, 1'b0, 1'b0);
    muldiv_start_E = 1'b0;
    for (int i = 1; i <= 4; i++) issue($sformatf("md2_busy%0d", i), 1'b1, 1'b0, 1'b1);
    issue("md2_free", 1'b0, 1'b0, 1'b0);

    // Reset two cycles into the busy window aborts it.
    clear_inputs();
    muldiv_start_E = 1'b1;
    issue("rst_start", 1'b0, 1'b0, 1'b0);
    muldiv_start_E = 1'b0;
    issue("rst_busy1", 1'b0, 1'b0, 1'b1);
    reset = 1'b1; hilo_rd_D = 1'b1;
    issue("rst_asserted", 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    issue("rst_after1", 1'b0, 1'b0, 1'b0);
    issue("rst_after2", 1'b0, 1'b0, 1'b0);

    // A start while busy restarts the full window.
    clear_inputs();
    muldiv_start_E = 1'b1;
    issue("reload_start", 1'b0, 1'b0, 1'b0);
    muldiv_start_E = 1'b0;
    issue("reload_b1", 1'b0, 1'b0, 1'b1);
    muldiv_start_E = 1'b1;
    issue("reload_again", 1'b0, 1'b0, 1'b1);
    muldiv_start_E = 1'b0;
    for (int i = 1; i <= 4; i++) issue($sformatf("reload_busy%0d", i), 1'b0, 1'b0, 1'b1);
    issue("reload_free", 1'b0, 1'b0, 1'b0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
